// File: rtl/adn_example_net_pkg.sv
// adn_example_net_pkg: packet header type, field widths and the traffic-pattern functions shared by ring and bench
package adn_example_net_pkg;
  localparam int id_w = 8;
  localparam int seq_w = 8;
  typedef struct packed {
    logic [id_w-1:0]  src;
    logic [id_w-1:0]  dest;
    logic [seq_w-1:0] seq;
  } hdr_t;
  function automatic logic [id_w-1:0] dest_of(int src, int k, int n);
    return id_w'((src + 1 + k % (n - 1)) % n);
  endfunction
  function automatic logic [31:0] payload_of(int src, int k);
    return 32'(k * (src + 1));
  endfunction
  // A sink sees every (n-1)th packet of a source, starting at that source's offset to it
  function automatic logic [seq_w-1:0] exp_seq(int self_id, int src, int c, int n);
    return seq_w'((self_id - src - 1 + 2 * n) % n + c * (n - 1));
  endfunction
endpackage

// File: rtl/adn_example_node.sv
// adn_example_node: ring node with input FIFO, packet generator, checking sink and forward-first output mux
module adn_example_node
  import adn_example_net_pkg::*;
#(
  parameter int num_nodes_p        = 4,
  parameter int payload_width_p    = 16,
  parameter int packets_per_node_p = 8,
  parameter int fifo_els_p         = 2,
  parameter int node_id_p          = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       in_v_i,
  input  hdr_t                       in_hdr_i,
  input  logic [payload_width_p-1:0] in_data_i,
  input  logic                       in_rdy_i,
  output logic                       acc_o,
  output logic                       fwd_o,
  output logic                       out_v_o,
  output hdr_t                       out_hdr_o,
  output logic [payload_width_p-1:0] out_data_o,
  input  logic                       out_rdy_i,
  output logic                       inject_o,
  output logic                       eject_o,
  output logic                       bad_o
);
  localparam int aw = fifo_els_p > 1 ? $clog2(fifo_els_p) : 1;
  localparam int cw = $clog2(fifo_els_p + 1);
  localparam int gw = $clog2(packets_per_node_p + 1);
  localparam int iw = $clog2(num_nodes_p);
  hdr_t                       mem_hdr  [2**aw];
  logic [payload_width_p-1:0] mem_data [2**aw];
  logic [seq_w-1:0]           rc_q     [num_nodes_p];
  logic [aw-1:0]              wp_q, wp_d, rp_q, rp_d;
  logic [cw-1:0]              cnt_q, cnt_d;
  logic [gw-1:0]              gen_q, gen_d;
  hdr_t                       h, gen_hdr;
  logic [payload_width_p-1:0] h_data, gen_data;
  logic [iw-1:0]              src;
  logic                       h_v, gen_v, push, pop;
  always_comb begin
    h = mem_hdr[rp_q];
    h_data = mem_data[rp_q];
    h_v = cnt_q != '0;
    src = h.src[iw-1:0];
    eject_o = h_v && h.dest == id_w'(node_id_p);
    fwd_o = h_v && !eject_o;
    acc_o = cnt_q != cw'(fifo_els_p) || eject_o;
    gen_v = gen_q != gw'(packets_per_node_p);
    gen_hdr = '{src: id_w'(node_id_p), dest: dest_of(node_id_p, int'(gen_q), num_nodes_p), seq: seq_w'(gen_q)};
    gen_data = payload_width_p'(payload_of(node_id_p, int'(gen_q)));
    out_v_o = fwd_o || gen_v;
    out_hdr_o = fwd_o ? h : gen_hdr;
    out_data_o = fwd_o ? h_data : gen_data;
    bad_o = eject_o && (h.seq != exp_seq(node_id_p, int'(src), int'(rc_q[src]), num_nodes_p) ||
                        h_data != payload_width_p'(payload_of(int'(h.src), int'(h.seq))));
  end
  // Handshake side kept apart from the head decode so ring-level ready has no loop
  always_comb begin
    inject_o = gen_v && !fwd_o && out_rdy_i;
    push = in_v_i && in_rdy_i;
    pop = eject_o || (fwd_o && out_rdy_i);
    wp_d = push ? (wp_q == aw'(fifo_els_p - 1) ? '0 : wp_q + aw'(1)) : wp_q;
    rp_d = pop ? (rp_q == aw'(fifo_els_p - 1) ? '0 : rp_q + aw'(1)) : rp_q;
    cnt_d = cnt_q + cw'(push) - cw'(pop);
    gen_d = gen_q + gw'(inject_o);
  end
  always_ff @(posedge clk_i)
    if (push) begin
      mem_hdr[wp_q] <= in_hdr_i;
      mem_data[wp_q] <= in_data_i;
    end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      gen_q <= '0;
      for (int n = 0; n < num_nodes_p; n++) rc_q[n] <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      gen_q <= gen_d;
      if (eject_o) rc_q[src] <= rc_q[src] + seq_w'(1);
    end
endmodule

// File: rtl/adn_example_net.sv
// adn_example_net: unidirectional ring of traffic nodes with aggregate sent/received counters and status
module adn_example_net
  import adn_example_net_pkg::*;
#(
  parameter int num_nodes_p        = 4,
  parameter int payload_width_p    = 16,
  parameter int packets_per_node_p = 8,
  parameter int fifo_els_p         = 2
) (
  input  logic                                                clk_i,
  input  logic                                                reset_i,
  output logic [$clog2(num_nodes_p*packets_per_node_p+1)-1:0] sent_count_o,
  output logic [$clog2(num_nodes_p*packets_per_node_p+1)-1:0] recv_count_o,
  output logic                                                done_o,
  output logic                                                error_o
);
  localparam int total = num_nodes_p * packets_per_node_p;
  localparam int cw = $clog2(total + 1);
  hdr_t                       l_hdr  [num_nodes_p];
  logic [payload_width_p-1:0] l_data [num_nodes_p];
  logic [num_nodes_p-1:0]     l_v, l_rdy, acc, fwd, inj, ej, bad;
  logic [cw-1:0]              sent_q, sent_d, recv_q, recv_d;
  logic                       done_q, done_d, err_q, err_d, r, run;
  int                         sum_s, sum_r;
  for (genvar g = 0; g < num_nodes_p; g++) begin : g_node
    localparam int p = (g + num_nodes_p - 1) % num_nodes_p;
    adn_example_node #(
      .num_nodes_p(num_nodes_p), .payload_width_p(payload_width_p),
      .packets_per_node_p(packets_per_node_p), .fifo_els_p(fifo_els_p), .node_id_p(g)
    ) u_node (
      .clk_i(clk_i), .reset_i(reset_i),
      .in_v_i(l_v[p]), .in_hdr_i(l_hdr[p]), .in_data_i(l_data[p]), .in_rdy_i(l_rdy[p]),
      .acc_o(acc[g]), .fwd_o(fwd[g]),
      .out_v_o(l_v[g]), .out_hdr_o(l_hdr[g]), .out_data_o(l_data[g]), .out_rdy_i(l_rdy[g]),
      .inject_o(inj[g]), .eject_o(ej[g]), .bad_o(bad[g])
    );
  end
  // A link is ready if some downstream node frees a slot through a chain of forwarders, or the full ring rotates
  always_comb begin
    r = 1'b0;
    run = 1'b1;
    for (int i = 0; i < num_nodes_p; i++) begin
      r = &fwd;
      run = 1'b1;
      for (int j = 1; j <= num_nodes_p; j++) begin
        r = r | (run & acc[(i + j) % num_nodes_p]);
        run = run & fwd[(i + j) % num_nodes_p];
      end
      l_rdy[i] = r;
    end
  end
  always_comb begin
    sum_s = int'(sent_q) + $countones(inj);
    sum_r = int'(recv_q) + $countones(ej);
    sent_d = sum_s > total ? cw'(total) : cw'(sum_s);
    recv_d = sum_r > total ? cw'(total) : cw'(sum_r);
    done_d = done_q || (sent_q == cw'(total) && recv_q == cw'(total));
    err_d = err_q || |bad;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      sent_q <= '0;
      recv_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
      recv_q <= recv_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign sent_count_o = sent_q;
  assign recv_count_o = recv_q;
  assign done_o = done_q;
  assign error_o = err_q;
endmodule

// File: tb/tb_adn_example_net.sv
// tb_adn_example_net: three ring configurations (defaults, one packet per node, single-entry FIFOs) checked against spec-level rules
module tb_adn_example_net;
  localparam int n = 4;
  localparam int tot0 = 32;
  localparam int tot1 = 4;
  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [5:0] sent0, recv0, sent2, recv2;
  logic [2:0] sent1, recv1;
  logic       done0, done1, done2, err0, err1, err2;
  int         n_assert = 0;
  int         n_fail = 0;
  int         ps [3];
  logic       full_prev [3];
  logic       done_exp [3];

  adn_example_net dut0 (.clk_i(clk_i), .reset_i(reset_i), .sent_count_o(sent0), .recv_count_o(recv0),
                        .done_o(done0), .error_o(err0));
  adn_example_net #(.packets_per_node_p(1)) dut1 (.clk_i(clk_i), .reset_i(reset_i), .sent_count_o(sent1),
                        .recv_count_o(recv1), .done_o(done1), .error_o(err1));
  adn_example_net #(.fifo_els_p(1)) dut2 (.clk_i(clk_i), .reset_i(reset_i), .sent_count_o(sent2),
                        .recv_count_o(recv2), .done_o(done2), .error_o(err2));

  always #25 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Per-cycle rules: zeros under reset, done one cycle after both counts hit the total, no errors, recv never ahead of sent
  task automatic check_cycle();
    logic [31:0] s [3];
    logic [31:0] r [3];
    int          t [3];
    logic        d [3];
    logic        e [3];
    s = '{32'(sent0), 32'(sent1), 32'(sent2)};
    r = '{32'(recv0), 32'(recv1), 32'(recv2)};
    t = '{tot0, tot1, tot0};
    d = '{done0, done1, done2};
    e = '{err0, err1, err2};
    for (int i = 0; i < 3; i++) begin
      if (!reset_i) begin
        done_exp[i] = 1'b0;
        full_prev[i] = 1'b0;
        ps[i] = 0;
        chk($sformatf("rst_sent%0d", i), s[i], 0);
        chk($sformatf("rst_recv%0d", i), r[i], 0);
      end else done_exp[i] = done_exp[i] | full_prev[i];
      chk($sformatf("done%0d", i), 32'(d[i]), 32'(done_exp[i]));
      chk($sformatf("error%0d", i), 32'(e[i]), 0);
      chk($sformatf("recv_le_sent%0d", i), 32'(r[i] <= s[i]), 1);
      chk($sformatf("sent_step%0d", i), 32'(s[i] >= 32'(ps[i]) && s[i] - 32'(ps[i]) <= 32'(n)), 1);
      chk($sformatf("sent_sat%0d", i), 32'(s[i] <= 32'(t[i])), 1);
      full_prev[i] = s[i] == 32'(t[i]) && r[i] == 32'(t[i]);
      ps[i] = int'(s[i]);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
    check_cycle();
  endtask

  task automatic async_reset_check(input string tag);
    reset_i = 1'b0;
    #1;
    chk({tag, "_sent0"}, 32'(sent0), 0);
    chk({tag, "_recv0"}, 32'(recv0), 0);
    chk({tag, "_done0"}, 32'(done0), 0);
    chk({tag, "_done1"}, 32'(done1), 0);
    chk({tag, "_sent2"}, 32'(sent2), 0);
  endtask

  task automatic run_to_done(input string tag);
    int cyc;
    cyc = 0;
    while (!(done0 && done1 && done2) && cyc < 10000) begin
      step();
      cyc++;
    end
    chk({tag, "_all_done"}, 32'(done0 && done1 && done2), 1);
    chk({tag, "_sent0"}, 32'(sent0), tot0);
    chk({tag, "_recv0"}, 32'(recv0), tot0);
    chk({tag, "_recv1"}, 32'(recv1), tot1);
    chk({tag, "_recv2"}, 32'(recv2), tot0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 3; i++) begin
      ps[i] = 0;
      full_prev[i] = 1'b0;
      done_exp[i] = 1'b0;
    end
    repeat (10) step();
    reset_i = 1'b1;
    step();
    chk("c1_sent0", 32'(sent0), 4);
    chk("c1_recv0", 32'(recv0), 0);
    chk("c1_sent1", 32'(sent1), 4);
    chk("c1_sent2", 32'(sent2), 4);
    step();
    chk("c2_sent0", 32'(sent0), 8);
    chk("c2_recv0", 32'(recv0), 4);
    chk("c2_recv1", 32'(recv1), 4);
    chk("c2_done1", 32'(done1), 0);
    step();
    chk("c3_done1", 32'(done1), 1);
    chk("c3_sent1", 32'(sent1), 4);
    cyc = 0;
    while (sent0 < 6'd10 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("reach10", 32'(sent0 >= 6'd10), 1);
    async_reset_check("midrst");
    repeat ($urandom_range(2, 6)) step();
    reset_i = 1'b1;
    repeat ($urandom_range(1, 40)) step();
    async_reset_check("randrst");
    repeat ($urandom_range(1, 5)) step();
    reset_i = 1'b1;
    run_to_done("run");
    repeat (1000) step();
    chk("hold_done0", 32'(done0), 1);
    chk("hold_done2", 32'(done2), 1);
    chk("hold_sent2", 32'(sent2), tot0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
